snake_tick_scheduler: RTL and testbench
=======================================

# snake_tick_scheduler

Timing scheduler for the greedy-snake game. It runs from the single system clock and produces two enables: a free-running 2 ms scan tick for display multiplexing, and a game-step request whose period depends on a player-adjustable speed level. The step request is handed to the game-update logic with a req/ack handshake. Missed steps are counted rather than queued. No derived clocks are generated; every output is a synchronous enable or level.

## Interface
- BASE_DIV, 200_000: clk cycles per scan tick (2 ms at 100 MHz).
- BASE_STEPS, 250: scan ticks per game step at speed level 0.
- STEP_DELTA, 25: scan ticks removed from the step period per speed level. Constraint: BASE_STEPS − 7·STEP_DELTA ≥ 1.
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- run  in  1  1 = game running; 0 = paused.
- speed_up  in  1  one-cycle pulse; raise the speed level.
- speed_down  in  1  one-cycle pulse; lower the speed level.
- step_ack  in  1  game logic has consumed the step; sampled only while step_req = 1.
- tick_2ms  out  1  one-cycle pulse every BASE_DIV cycles; free-running.
- step_req  out  1  game-step request; held until acknowledged.
- speed_level  out  3  current speed level, 0 (slowest) to 7 (fastest).
- overrun_cnt  out  8  number of steps that fell due while step_req was already high; saturates at 255.

## Operation
- **Base counter** (width clog2(BASE_DIV))
  - Counts 0 … BASE_DIV−1, then wraps.
  - tick_2ms is registered and high for exactly one cycle per wrap.
  - Unaffected by run or by the handshake.
- **Step period**
  - period = BASE_STEPS − speed_level·STEP_DELTA.
  - Computed unsigned, wide enough for BASE_STEPS.
- **Step counter** (width clog2(BASE_STEPS+1))
  - Advances on tick_2ms only when run = 1.
  - A step is *due* on a qualifying tick when step_cnt+1 ≥ period; step_cnt then clears to 0.
  - The ≥ comparison matters: after a speed increase, a step_cnt already beyond the new period fires on the next qualifying tick.
- **States**
  - PAUSED: run = 0. step_cnt holds its value and is not cleared.
  - COUNT: run = 1, step_req = 0.
  - PENDING: step_req = 1.
  - COUNT → PENDING when a step is due.
  - PENDING → COUNT on step_ack = 1 with no new due step in the same cycle.
  - Any state → PAUSED when run = 0. From PAUSED, the return state is selected by step_req.
- **Handshake**
  - step_req rises on the edge following a due step.
  - step_req falls on the edge following step_ack = 1.
  - step_ack while step_req = 0 is ignored.
  - Ack and a due step in the same cycle: step_req stays 1 (fresh request), overrun unchanged.
  - Due step while step_req = 1 and no ack: overrun_cnt +1, saturating at 255; no queuing.
  - Pausing does not withdraw an outstanding step_req; ack is still honoured while paused.
- **Speed level**
  - speed_up increments, saturating at 7.
  - speed_down decrements, saturating at 0.
  - Both asserted in the same cycle: no change.
  - Changes take effect for the period comparison on the following cycle. step_cnt is not reset.
- **Reset**
  - Effective on any cycle, including mid-request.
  - Clears the base counter, step_cnt, step_req, overrun_cnt, speed_level and tick_2ms.
  - State goes to COUNT (or PAUSED if run = 0 on the next cycle).

## Timing
- Reset values: tick_2ms = 0, step_req = 0, speed_level = 0, overrun_cnt = 0.
- Cycle 1 is the first cycle with rst low. tick_2ms is high in cycles BASE_DIV, 2·BASE_DIV, and so on.
- Latency from the due tick_2ms cycle to step_req high: 1 cycle.
- Latency from step_ack to step_req low: 1 cycle.
- Step-to-step spacing is exactly period·BASE_DIV cycles while run = 1, independent of ack latency.
- speed_level and overrun_cnt are registered and update 1 cycle after their cause.

## Test plan
Bench parameters: BASE_DIV = 10, BASE_STEPS = 8, STEP_DELTA = 1 (periods 8 down to 1).
- **Reset and scan tick:** rst high 3 cycles, then low, run = 0 → tick_2ms high only in cycles 10, 20, 30; step_req = 0; speed_level = 0; overrun_cnt = 0.
- **Basic step:** run = 1, level 0, ack 2 cycles after each request → step_req high cycles 81–83, then 161–163; overrun_cnt stays 0.
- **Overrun:** run = 1, never ack → step_req stays high from cycle 81; overrun_cnt = 1, 2, 3 in cycles 161, 241, 321; after 300 periods it reads 255.
- **Speed control:**
  - 9 speed_up pulses → speed_level = 7; steps every 10 cycles.
  - speed_up and speed_down in the same cycle → level unchanged.
  - At level 0 with step_cnt = 5, raise to level 4 (period 4) → step due on the next tick.
- **Pause and resume:** drop run at step_cnt = 3 for 50 ticks → no step_req; tick_2ms continues every 10 cycles. Restore run → step_req rises 1 cycle after the 5th subsequent tick.
- **Reset mid-request:** step_req = 1, overrun_cnt = 2, level 5, then rst for 1 cycle → next cycle all outputs at reset values; first tick_2ms 10 cycles after rst falls.

Source files
------------

// File: rtl/snake_tick_scheduler.sv
// snake_tick_scheduler
//   Timing scheduler for the greedy-snake game. From the single system clock
//   it produces a free-running scan tick for display multiplexing and a
//   game-step request. The step period depends on the current speed level.
//   The request is handed to the game-update logic with a req/ack handshake.
//   Steps that fall due while a request is still outstanding are counted
//   rather than queued. Every output is a synchronous enable or level, and
//   no derived clocks are generated.
//
// Parameters
//   BASE_DIV    clk cycles per scan tick (must be >= 2)
//   BASE_STEPS  scan ticks per game step at speed level 0
//   STEP_DELTA  scan ticks removed from the step period per speed level
//               (BASE_STEPS - 7*STEP_DELTA must be >= 1)
//
// Ports
//   clk          system clock
//   rst          synchronous, active-high reset
//   run          1 = game running, 0 = paused
//   speed_up     one-cycle pulse, raise speed level (saturates at 7)
//   speed_down   one-cycle pulse, lower speed level (saturates at 0)
//   step_ack     game logic consumed the step (only honoured while step_req)
//   tick_2ms     one-cycle pulse every BASE_DIV cycles, free-running
//   step_req     game-step request, held until acknowledged
//   speed_level  current speed level, 0 (slowest) .. 7 (fastest)
//   overrun_cnt  steps that fell due while step_req was already high (sat 255)
//
// State table
//   state       | meaning
//   st_paused   | run = 0; step counter frozen, outstanding request kept
//   st_count    | run = 1, no request outstanding, counting scan ticks
//   st_pending  | step_req = 1, waiting for step_ack

module snake_tick_scheduler #(
  parameter int BASE_DIV   = 200_000,
  parameter int BASE_STEPS = 250,
  parameter int STEP_DELTA = 25
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       run,
  input  logic       speed_up,
  input  logic       speed_down,
  input  logic       step_ack,
  output logic       tick_2ms,
  output logic       step_req,
  output logic [2:0] speed_level,
  output logic [7:0] overrun_cnt
);

  localparam int BW = (BASE_DIV > 1) ? $clog2(BASE_DIV) : 1;
  localparam int SW = $clog2(BASE_STEPS + 1);

  localparam logic [BW-1:0] BASE_LAST = BW'(BASE_DIV - 1);
  // tick_2ms is registered, so it is armed one count before the wrap to
  // land in the same cycle that the counter sits at its last value.
  localparam logic [BW-1:0] TICK_ARM  = BW'(BASE_DIV - 2);

  typedef enum logic [1:0] {
    st_paused  = 2'd0,
    st_count   = 2'd1,
    st_pending = 2'd2
  } state_t;

  state_t        state;
  logic [BW-1:0] base_cnt;
  logic [SW-1:0] step_cnt;
  logic [SW-1:0] period;
  logic [SW:0]   cnt_inc;
  logic          qual_tick;
  logic          step_due;
  logic          req_next;
  logic          overrun_hit;

  // --------------------------------------------------------------------
  // Scan tick: free-running, independent of run and of the handshake.
  // --------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      base_cnt <= '0;
      tick_2ms <= 1'b0;
    end else begin
      if (base_cnt == BASE_LAST) begin
        base_cnt <= '0;
      end else begin
        base_cnt <= base_cnt + 1'b1;
      end
      tick_2ms <= (base_cnt == TICK_ARM);
    end
  end

  // --------------------------------------------------------------------
  // Speed level: opposing pulses in the same cycle cancel.
  // --------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      speed_level <= 3'd0;
    end else if (speed_up && !speed_down) begin
      if (speed_level != 3'd7) begin
        speed_level <= speed_level + 3'd1;
      end
    end else if (speed_down && !speed_up) begin
      if (speed_level != 3'd0) begin
        speed_level <= speed_level - 3'd1;
      end
    end
  end

  // --------------------------------------------------------------------
  // Step due detection. The >= compare lets a step counter that is already
  // past a freshly shortened period fire on the next qualifying tick
  // instead of running all the way round.
  // --------------------------------------------------------------------
  always_comb begin
    period      = SW'(BASE_STEPS - (int'(speed_level) * STEP_DELTA));
    cnt_inc     = {1'b0, step_cnt} + (SW+1)'(1);
    qual_tick   = tick_2ms & run;
    step_due    = qual_tick & (cnt_inc >= {1'b0, period});
    // A due step always (re)raises the request; otherwise an ack drops it.
    req_next    = step_due | (step_req & ~step_ack);
    overrun_hit = step_due & step_req & ~step_ack;
  end

  // --------------------------------------------------------------------
  // Step FSM with registered request and overrun counter.
  // --------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= st_count;
      step_cnt    <= '0;
      step_req    <= 1'b0;
      overrun_cnt <= 8'd0;
    end else begin
      if (qual_tick) begin
        step_cnt <= step_due ? '0 : cnt_inc[SW-1:0];
      end

      step_req <= req_next;

      if (overrun_hit && (overrun_cnt != 8'hFF)) begin
        overrun_cnt <= overrun_cnt + 8'd1;
      end

      // Leaving pause, the return state follows the outstanding request.
      if (!run) begin
        state <= st_paused;
      end else if (req_next) begin
        state <= st_pending;
      end else begin
        state <= st_count;
      end
    end
  end

  a_pending_has_req : assert property (@(posedge clk) disable iff (rst)
    (state == st_pending) |-> step_req);
  a_count_no_req : assert property (@(posedge clk) disable iff (rst)
    (state == st_count) |-> !step_req);

endmodule

// File: tb/tb_snake_tick_scheduler.sv
module tb_snake_tick_scheduler;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       run = 1'b0;
  logic       speed_up = 1'b0;
  logic       speed_down = 1'b0;
  logic       step_ack = 1'b0;
  logic       tick_2ms;
  logic       step_req;
  logic [2:0] speed_level;
  logic [7:0] overrun_cnt;

  snake_tick_scheduler #(
    .BASE_DIV   (10),
    .BASE_STEPS (8),
    .STEP_DELTA (1)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .run         (run),
    .speed_up    (speed_up),
    .speed_down  (speed_down),
    .step_ack    (step_ack),
    .tick_2ms    (tick_2ms),
    .step_req    (step_req),
    .speed_level (speed_level),
    .overrun_cnt (overrun_cnt)
  );

  always #5 clk = ~clk;

  typedef struct { int cyc; int val; } ev_t;
  typedef struct { int cyc; int sel; int val; } probe_t;

  int     q_tick[$];
  int     q_rise[$];
  int     q_fall[$];
  ev_t    q_ovr[$];
  probe_t q_probe[$];

  int         n_cmp = 0;
  int         n_bad = 0;
  int         cyc = 0;
  int         dcyc = 0;
  bit         chk_tick = 1'b0;
  logic       prev_req = 1'b0;
  logic [7:0] prev_ovr = 8'd0;

  string pnames[4] = '{"tick_2ms", "step_req", "speed_level", "overrun_cnt"};

  function automatic void chk(string name, int act, int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  function automatic void unexpected(string name, int act);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: unexpected event, value %0d (cycle %0d)", name, act, cyc);
  endfunction

  function automatic int probe_val(int sel);
    case (sel)
      0:       return int'(tick_2ms);
      1:       return int'(step_req);
      2:       return int'(speed_level);
      default: return int'(overrun_cnt);
    endcase
  endfunction

  // Monitor: pops expectations whenever the DUT shows an event.
  always @(negedge clk) begin
    probe_t p;
    ev_t    e;
    if (rst) cyc = 0;
    else     cyc = cyc + 1;
    if (!rst) begin
      while (q_probe.size() > 0 && q_probe[0].cyc <= cyc) begin
        p = q_probe.pop_front();
        if (p.cyc < cyc) chk("probe_cycle", cyc, p.cyc);
        else             chk(pnames[p.sel], probe_val(p.sel), p.val);
      end
      if (cyc >= 2) begin
        if (chk_tick && tick_2ms) begin
          if (q_tick.size() == 0) unexpected("tick_2ms", cyc);
          else chk("tick_cycle", cyc, q_tick.pop_front());
        end
        if (step_req && !prev_req) begin
          if (q_rise.size() == 0) unexpected("step_req_rise", cyc);
          else chk("req_rise_cycle", cyc, q_rise.pop_front());
        end
        if (!step_req && prev_req) begin
          if (q_fall.size() == 0) unexpected("step_req_fall", cyc);
          else chk("req_fall_cycle", cyc, q_fall.pop_front());
        end
        if (overrun_cnt != prev_ovr) begin
          if (q_ovr.size() == 0) unexpected("overrun_cnt", int'(overrun_cnt));
          else begin
            e = q_ovr.pop_front();
            chk("ovr_cycle", cyc, e.cyc);
            chk("ovr_value", int'(overrun_cnt), e.val);
          end
        end
      end
    end
    prev_req = step_req;
    prev_ovr = overrun_cnt;
  end

  task automatic run_to(int c);
    while (dcyc < c) begin
      @(posedge clk);
      #1;
      dcyc++;
    end
  endtask

  task automatic do_reset(int n);
    rst        = 1'b1;
    speed_up   = 1'b0;
    speed_down = 1'b0;
    step_ack   = 1'b0;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
    rst  = 1'b0;
    dcyc = 1;
  endtask

  task automatic probe(int c, int sel, int v);
    probe_t p;
    p.cyc = c; p.sel = sel; p.val = v;
    q_probe.push_back(p);
  endtask

  task automatic exp_ovr(int c, int v);
    ev_t e;
    e.cyc = c; e.val = v;
    q_ovr.push_back(e);
  endtask

  task automatic ack_at(int c);
    run_to(c);
    step_ack = 1'b1;
    run_to(c + 1);
    step_ack = 1'b0;
  endtask

  task automatic drain(string tag);
    chk({tag, "_tick_left"},  q_tick.size(),  0);
    chk({tag, "_rise_left"},  q_rise.size(),  0);
    chk({tag, "_fall_left"},  q_fall.size(),  0);
    chk({tag, "_ovr_left"},   q_ovr.size(),   0);
    chk({tag, "_probe_left"}, q_probe.size(), 0);
    q_tick.delete(); q_rise.delete(); q_fall.delete();
    q_ovr.delete();  q_probe.delete();
  endtask

  initial begin
    // Reset and scan tick, paused
    do_reset(3);
    run = 1'b0;
    chk_tick = 1'b1;
    probe(1, 0, 0); probe(1, 1, 0); probe(1, 2, 0); probe(1, 3, 0);
    probe(9, 0, 0); probe(35, 1, 0); probe(35, 3, 0);
    q_tick.push_back(10); q_tick.push_back(20); q_tick.push_back(30);
    run_to(36);
    drain("reset");
    chk_tick = 1'b0;

    // Basic step at level 0 with ack two cycles after request
    do_reset(3);
    run = 1'b1;
    q_rise.push_back(81);  q_fall.push_back(84);
    q_rise.push_back(161); q_fall.push_back(164);
    probe(170, 3, 0);
    ack_at(50);            // ignored: no request outstanding
    ack_at(83);
    ack_at(163);
    run_to(171);
    drain("basic");

    // Overrun, never acknowledged, saturates at 255
    do_reset(3);
    run = 1'b1;
    q_rise.push_back(81);
    for (int k = 1; k <= 255; k++) exp_ovr(80 * k + 81, k);
    probe(24081, 3, 255);
    probe(24081, 1, 1);
    run_to(24100);
    drain("overrun");

    // Speed to max, steps every tick, ack coincident with due step
    do_reset(3);
    run = 1'b0;
    probe(2, 2, 1); probe(14, 2, 7); probe(16, 2, 7); probe(18, 2, 7);
    for (int c = 1; c <= 17; c += 2) begin
      run_to(c);
      speed_up = 1'b1;
      run_to(c + 1);
      speed_up = 1'b0;
    end
    run_to(21);
    run = 1'b1;
    q_rise.push_back(31); q_fall.push_back(33);
    q_rise.push_back(41); q_fall.push_back(43);
    q_rise.push_back(51); q_fall.push_back(63);
    probe(61, 1, 1); probe(62, 3, 0);
    ack_at(32);
    ack_at(42);
    ack_at(60);
    ack_at(62);
    run_to(64);
    run = 1'b0;
    probe(71, 2, 7); probe(73, 2, 6); probe(75, 2, 6);
    run_to(70); speed_up = 1'b1; speed_down = 1'b1;
    run_to(71); speed_up = 1'b0; speed_down = 1'b0;
    run_to(72); speed_down = 1'b1;
    run_to(73); speed_down = 1'b0;
    run_to(74); speed_up = 1'b1; speed_down = 1'b1;
    run_to(75); speed_up = 1'b0; speed_down = 1'b0;
    run_to(78);
    drain("speed_max");

    // Raise to level 4 with step_cnt = 5, then saturate downwards
    do_reset(3);
    run = 1'b1;
    probe(55, 2, 4);
    q_rise.push_back(61);  q_fall.push_back(63);
    q_rise.push_back(101); q_fall.push_back(103);
    run_to(51);
    speed_up = 1'b1;
    run_to(55);
    speed_up = 1'b0;
    ack_at(62);
    ack_at(102);
    probe(105, 2, 3); probe(113, 2, 0);
    for (int c = 104; c <= 112; c += 2) begin
      run_to(c);
      speed_down = 1'b1;
      run_to(c + 1);
      speed_down = 1'b0;
    end
    run_to(116);
    drain("speed_jump");

    // Pause at step_cnt = 3 for 50 ticks, resume, ack while paused
    do_reset(3);
    run = 1'b1;
    run_to(31);
    run = 1'b0;
    chk_tick = 1'b1;
    for (int c = 40; c <= 590; c += 10) q_tick.push_back(c);
    probe(530, 1, 0);
    q_rise.push_back(581);
    q_fall.push_back(588);
    run_to(531);
    run = 1'b1;
    run_to(585);
    run = 1'b0;
    ack_at(587);
    run_to(596);
    drain("pause");
    chk_tick = 1'b0;

    // Reset in the middle of an outstanding request
    do_reset(3);
    run = 1'b1;
    speed_up = 1'b1;
    run_to(6);
    speed_up = 1'b0;
    probe(6, 2, 5);
    q_rise.push_back(31);
    exp_ovr(61, 1);
    exp_ovr(91, 2);
    probe(94, 1, 1); probe(94, 2, 5); probe(94, 3, 2);
    run_to(95);
    drain("pre_reset");
    do_reset(1);
    chk_tick = 1'b1;
    probe(1, 0, 0); probe(1, 1, 0); probe(1, 2, 0); probe(1, 3, 0);
    q_tick.push_back(10); q_tick.push_back(20);
    run_to(26);
    drain("mid_reset");
    chk_tick = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "time limit");
  end

endmodule
